// File: rtl/vip_frame_sequencer_pkg.sv
// vip_frame_sequencer_pkg
// Shared definitions for the VIP frame sequencer: FSM state encoding,
// reset-time frame dimensions and the raster counter width.
package vip_frame_sequencer_pkg;

   localparam int unsigned CNT_W      = 16;
   localparam int unsigned DEF_WIDTH  = 640;
   localparam int unsigned DEF_HEIGHT = 480;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_SEND   = 3'd2,
      ST_STREAM = 3'd3,
      ST_FLUSH  = 3'd4
   } state_e;

endpackage

// File: rtl/vip_frame_sequencer_raster.sv
// vip_raster_counter
// Column/row wrap counter for the pixel raster.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   beat              advance by one pixel
//   clear             return to (0,0); has priority over beat
//   width, height     frame dimensions (non-zero)
//   x, y              position of the next pixel
//   last_col          x is the last column of a row
//   last_pix          x,y is the last pixel of the frame
module vip_raster_counter #(
   parameter int unsigned CNT_W = vip_frame_sequencer_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             beat,
   input  logic             clear,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] height,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             last_col,
   output logic             last_pix
);
   import vip_frame_sequencer_pkg::*;

   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;

   assign x        = x_q;
   assign y        = y_q;
   assign last_col = (x_q == (width - ONE));
   assign last_pix = last_col && (y_q == (height - ONE));

   // Next raster position: the last pixel wraps both axes back to the origin.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = ZERO;
         y_d = ZERO;
      end else if (beat) begin
         if (last_pix) begin
            x_d = ZERO;
            y_d = ZERO;
         end else if (last_col) begin
            x_d = ZERO;
            y_d = y_q + ONE;
         end else begin
            x_d = x_q + ONE;
            y_d = y_q;
         end
      end else begin
         x_d = x_q;
         y_d = y_q;
      end
   end

   // Raster position registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         x_q <= ZERO;
         y_q <= ZERO;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/vip_frame_sequencer.sv
// vip_frame_sequencer
// Frame-level controller for the VIP pixel core. Latches dimensions from
// decoded control packets into shadow registers, commits them at frame
// boundaries, issues the outgoing control packet when the encoder is free,
// gates pixel reads and checks end_of_video against the expected size.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   vip_ctrl_valid/width_in/height_in/interlaced_in   decoded control packet
//   vip_ctrl_busy, vip_ctrl_send  encoder handshake
//   width_out/height_out/interlaced_out               current frame format
//   beat_in, eop_in               accepted pixel and its end_of_video flag
//   proc_enable, drop             core read permit / discard accepted beats
//   x_pos, y_pos, sof, eol_pulse  raster position and markers
//   frame_done, err_short, err_long, frame_count      frame status
module vip_frame_sequencer #(
   parameter int unsigned DEF_WIDTH  = vip_frame_sequencer_pkg::DEF_WIDTH,
   parameter int unsigned DEF_HEIGHT = vip_frame_sequencer_pkg::DEF_HEIGHT,
   parameter int unsigned CNT_W      = vip_frame_sequencer_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vip_ctrl_valid,
   input  logic [CNT_W-1:0] width_in,
   input  logic [CNT_W-1:0] height_in,
   input  logic [3:0]       interlaced_in,
   input  logic             vip_ctrl_busy,
   output logic             vip_ctrl_send,
   output logic [CNT_W-1:0] width_out,
   output logic [CNT_W-1:0] height_out,
   output logic [3:0]       interlaced_out,
   input  logic             beat_in,
   input  logic             eop_in,
   output logic             proc_enable,
   output logic             drop,
   output logic [CNT_W-1:0] x_pos,
   output logic [CNT_W-1:0] y_pos,
   output logic             sof,
   output logic             eol_pulse,
   output logic             frame_done,
   output logic             err_short,
   output logic             err_long,
   output logic [CNT_W-1:0] frame_count
);
   import vip_frame_sequencer_pkg::*;

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEF_WIDTH);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HEIGHT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] shd_w_q, shd_w_d, shd_h_q, shd_h_d;
   logic [3:0]       shd_i_q, shd_i_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] width_q, width_d, height_q, height_d;
   logic [3:0]       intl_q, intl_d;
   logic             send_q, send_d, pe_q, pe_d, drop_q, drop_d;
   logic             eol_q, eol_d, done_q, done_d;
   logic             es_q, es_d, el_q, el_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic             load_s, cnt_beat_s, cnt_clear_s, last_col_s, last_pix_s;

   vip_raster_counter #(.CNT_W(CNT_W)) u_raster (
      .clk      (clk),
      .rst      (rst),
      .beat     (cnt_beat_s),
      .clear    (cnt_clear_s),
      .width    (width_q),
      .height   (height_q),
      .x        (x_pos),
      .y        (y_pos),
      .last_col (last_col_s),
      .last_pix (last_pix_s)
   );

   // A packet with either dimension zero is malformed and never reaches the shadow.
   assign load_s = vip_ctrl_valid && (width_in != ZERO) && (height_in != ZERO);

   assign vip_ctrl_send  = send_q;
   assign width_out      = width_q;
   assign height_out     = height_q;
   assign interlaced_out = intl_q;
   assign proc_enable    = pe_q;
   assign drop           = drop_q;
   assign eol_pulse      = eol_q;
   assign frame_done     = done_q;
   assign err_short      = es_q;
   assign err_long       = el_q;
   assign frame_count    = fcnt_q;
   assign sof            = (state_q == ST_STREAM) && (x_pos == ZERO) && (y_pos == ZERO);

   // Next-state, shadow bookkeeping and registered output values.
   always_comb begin
      state_d     = state_q;
      shd_w_d     = load_s ? width_in : shd_w_q;
      shd_h_d     = load_s ? height_in : shd_h_q;
      shd_i_d     = load_s ? interlaced_in : shd_i_q;
      pend_d      = pend_q;
      width_d     = width_q;
      height_d    = height_q;
      intl_d      = intl_q;
      send_d      = 1'b0;
      eol_d       = 1'b0;
      done_d      = 1'b0;
      es_d        = es_q;
      el_d        = el_q;
      fcnt_d      = fcnt_q;
      cnt_beat_s  = 1'b0;
      cnt_clear_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pend_q) state_d = ST_ARM;
            else        state_d = ST_IDLE;
         end
         ST_ARM: begin
            width_d     = shd_w_q;
            height_d    = shd_h_q;
            intl_d      = shd_i_q;
            pend_d      = 1'b0;
            cnt_clear_s = 1'b1;
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (!vip_ctrl_busy) begin
               send_d  = 1'b1;
               state_d = ST_STREAM;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_STREAM: begin
            if (beat_in) begin
               cnt_beat_s = 1'b1;
               eol_d      = last_col_s;
               if (eop_in) begin
                  // Good or short, the frame closes here and the next one starts clean.
                  if (last_pix_s) begin
                     done_d = 1'b1;
                     fcnt_d = fcnt_q + ONE;
                  end else begin
                     es_d = 1'b1;
                  end
                  cnt_clear_s = 1'b1;
                  state_d     = pend_q ? ST_ARM : ST_SEND;
               end else if (last_pix_s) begin
                  el_d    = 1'b1;
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_STREAM;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_FLUSH: begin
            // Overlong frame: swallow beats without moving the raster until eop.
            if (beat_in && eop_in) begin
               cnt_clear_s = 1'b1;
               state_d     = pend_q ? ST_ARM : ST_SEND;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A packet coinciding with ARM survives as the next pending one.
      if (load_s) pend_d = 1'b1;
      else        pend_d = pend_d;

      pe_d   = (state_d == ST_STREAM) || (state_d == ST_FLUSH);
      drop_d = (state_d == ST_FLUSH);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         shd_w_q  <= DEF_W;
         shd_h_q  <= DEF_H;
         shd_i_q  <= 4'd0;
         pend_q   <= 1'b0;
         width_q  <= DEF_W;
         height_q <= DEF_H;
         intl_q   <= 4'd0;
         send_q   <= 1'b0;
         pe_q     <= 1'b0;
         drop_q   <= 1'b0;
         eol_q    <= 1'b0;
         done_q   <= 1'b0;
         es_q     <= 1'b0;
         el_q     <= 1'b0;
         fcnt_q   <= ZERO;
      end else begin
         state_q  <= state_d;
         shd_w_q  <= shd_w_d;
         shd_h_q  <= shd_h_d;
         shd_i_q  <= shd_i_d;
         pend_q   <= pend_d;
         width_q  <= width_d;
         height_q <= height_d;
         intl_q   <= intl_d;
         send_q   <= send_d;
         pe_q     <= pe_d;
         drop_q   <= drop_d;
         eol_q    <= eol_d;
         done_q   <= done_d;
         es_q     <= es_d;
         el_q     <= el_d;
         fcnt_q   <= fcnt_d;
      end
   end

endmodule

// File: tb/tb_vip_frame_sequencer.sv
module tb_vip_frame_sequencer;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vip_ctrl_valid = 1'b0;
   logic [CW-1:0] width_in = 16'd0;
   logic [CW-1:0] height_in = 16'd0;
   logic [3:0]    interlaced_in = 4'd0;
   logic          vip_ctrl_busy = 1'b1;
   logic          vip_ctrl_send;
   logic [CW-1:0] width_out, height_out;
   logic [3:0]    interlaced_out;
   logic          beat_in = 1'b0;
   logic          eop_in = 1'b0;
   logic          proc_enable, drop, sof, eol_pulse, frame_done, err_short, err_long;
   logic [CW-1:0] x_pos, y_pos, frame_count;

   int n_checks = 0;
   int n_errors = 0;

   vip_frame_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .vip_ctrl_valid (vip_ctrl_valid),
      .width_in       (width_in),
      .height_in      (height_in),
      .interlaced_in  (interlaced_in),
      .vip_ctrl_busy  (vip_ctrl_busy),
      .vip_ctrl_send  (vip_ctrl_send),
      .width_out      (width_out),
      .height_out     (height_out),
      .interlaced_out (interlaced_out),
      .beat_in        (beat_in),
      .eop_in         (eop_in),
      .proc_enable    (proc_enable),
      .drop           (drop),
      .x_pos          (x_pos),
      .y_pos          (y_pos),
      .sof            (sof),
      .eol_pulse      (eol_pulse),
      .frame_done     (frame_done),
      .err_short      (err_short),
      .err_long       (err_long),
      .frame_count    (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic          busy;
      logic          beat;
      logic          eop;
      logic [CW-1:0] win;
      logic [CW-1:0] hin;
      logic          e_send;
      logic          e_pe;
      logic          e_drop;
      logic          e_eol;
      logic          e_done;
      logic [CW-1:0] e_x;
      logic [CW-1:0] e_y;
      logic [CW-1:0] e_fc;
      logic [CW-1:0] e_w;
   } vec_t;

   vec_t vecs[14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Release busy until the sequencer issues its control packet (bounded).
   task automatic wait_send(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         vip_ctrl_busy = 1'b0;
         tick();
         if (vip_ctrl_send === 1'b1) seen = 1'b1;
      end
      vip_ctrl_busy = 1'b1;
      chk(name, 96'(seen), 96'(1'b1));
   endtask

   task automatic beat(input logic eop);
      beat_in = 1'b1;
      eop_in  = eop;
      tick();
      beat_in = 1'b0;
      eop_in  = 1'b0;
   endtask

   task automatic chk_reset_state(input string name);
      chk(name, 96'({vip_ctrl_send, proc_enable, drop, sof, eol_pulse, frame_done, err_short, err_long,
                     interlaced_out, width_out, height_out, x_pos, y_pos, frame_count}),
                96'({8'h00, 4'h0, 16'd640, 16'd480, 16'd0, 16'd0, 16'd0}));
   endtask

   initial begin
      // in: valid busy beat eop win hin | exp: send pe drop eol done x y fc w
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd640};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd640};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd4};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd4};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0, 16'd0, 16'd4};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0, 16'd0, 16'd4};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd0, 16'd0, 16'd4};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd1, 16'd0, 16'd4};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1, 16'd0, 16'd4};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1, 16'd0, 16'd4};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1, 16'd0, 16'd4};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 16'd1, 16'd4};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd1, 16'd4};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd1, 16'd4};

      // Reset state
      rst = 1'b0;
      tick();
      tick();
      chk_reset_state("reset_values");
      rst = 1'b1;

      // Good 4x2 frame, cycle by cycle
      interlaced_in = 4'd3;
      for (int i = 0; i < 14; i++) begin
         vip_ctrl_valid = vecs[i].valid;
         vip_ctrl_busy  = vecs[i].busy;
         beat_in        = vecs[i].beat;
         eop_in         = vecs[i].eop;
         width_in       = vecs[i].win;
         height_in      = vecs[i].hin;
         tick();
         chk($sformatf("vec%0d", i),
             96'({vip_ctrl_send, proc_enable, drop, eol_pulse, frame_done, x_pos, y_pos, frame_count, width_out}),
             96'({vecs[i].e_send, vecs[i].e_pe, vecs[i].e_drop, vecs[i].e_eol, vecs[i].e_done,
                  vecs[i].e_x, vecs[i].e_y, vecs[i].e_fc, vecs[i].e_w}));
         if (i == 3) chk("sof_first_beat", 96'({sof, height_out, interlaced_out}), 96'({1'b1, 16'd2, 4'd3}));
      end
      vip_ctrl_valid = 1'b0;
      beat_in = 1'b0;
      eop_in = 1'b0;

      // Busy held for five cycles while a packet is pending
      vip_ctrl_valid = 1'b1;
      width_in = 16'd4;
      height_in = 16'd2;
      interlaced_in = 4'd5;
      tick();
      vip_ctrl_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("busy_hold%0d", i), 96'({vip_ctrl_send, proc_enable}), 96'({1'b0, 1'b0}));
      end
      vip_ctrl_busy = 1'b0;
      tick();
      vip_ctrl_busy = 1'b1;
      chk("send_after_busy", 96'({vip_ctrl_send, proc_enable}), 96'({1'b1, 1'b1}));
      tick();
      chk("send_one_cycle", 96'({vip_ctrl_send, proc_enable}), 96'({1'b0, 1'b1}));

      // Short frame: eop on beat 5
      for (int i = 0; i < 4; i++) beat(1'b0);
      chk("short_pre", 96'({x_pos, y_pos, err_short}), 96'({16'd0, 16'd1, 1'b0}));
      beat(1'b1);
      chk("short_flag", 96'({err_short, err_long, frame_done, frame_count, x_pos, y_pos}),
                        96'({1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 16'd0}));
      tick();
      tick();
      chk("short_next", 96'({x_pos, y_pos, interlaced_out, proc_enable, err_short}),
                        96'({16'd0, 16'd0, 4'd5, 1'b0, 1'b1}));

      // Long frame: 8 beats without eop, then flush 3 beats
      wait_send("send_long");
      for (int i = 0; i < 7; i++) beat(1'b0);
      chk("long_pre", 96'({err_long, x_pos, y_pos}), 96'({1'b0, 16'd3, 16'd1}));
      beat(1'b0);
      chk("long_flag", 96'({err_long, drop, proc_enable, frame_done, x_pos, y_pos}),
                       96'({1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0}));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("flush_drop%0d", i), 96'({drop, proc_enable}), 96'({1'b1, 1'b1}));
         beat(i == 2);
         chk($sformatf("flush_hold%0d", i), 96'({frame_done, frame_count, x_pos, y_pos}),
                                            96'({1'b0, 16'd1, 16'd0, 16'd0}));
      end
      chk("flush_exit", 96'({drop, proc_enable, err_long, err_short}), 96'({1'b0, 1'b0, 1'b1, 1'b1}));

      // Mid-frame control packet 2x2 during a 4x2 frame
      wait_send("send_mid");
      for (int i = 0; i < 7; i++) begin
         if (i == 1) begin
            vip_ctrl_valid = 1'b1;
            width_in = 16'd2;
            height_in = 16'd2;
            interlaced_in = 4'd1;
         end
         beat(1'b0);
         vip_ctrl_valid = 1'b0;
         chk($sformatf("mid_w%0d", i), 96'({width_out, height_out}), 96'({16'd4, 16'd2}));
      end
      beat(1'b1);
      chk("mid_done", 96'({frame_done, frame_count, width_out}), 96'({1'b1, 16'd2, 16'd4}));
      wait_send("send_2x2");
      chk("new_dims", 96'({width_out, height_out, interlaced_out}), 96'({16'd2, 16'd2, 4'd1}));
      beat(1'b0);
      beat(1'b0);
      chk("2x2_wrap", 96'({x_pos, y_pos, eol_pulse}), 96'({16'd0, 16'd1, 1'b1}));
      beat(1'b0);
      beat(1'b1);
      chk("2x2_done", 96'({frame_done, frame_count, err_long}), 96'({1'b1, 16'd3, 1'b1}));

      // Zero-dimension packets are ignored: stays idle
      rst = 1'b0;
      tick();
      rst = 1'b1;
      vip_ctrl_valid = 1'b1;
      width_in = 16'd0;
      height_in = 16'd3;
      tick();
      width_in = 16'd5;
      height_in = 16'd0;
      tick();
      vip_ctrl_valid = 1'b0;
      vip_ctrl_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("zero_idle%0d", i), 96'({vip_ctrl_send, proc_enable, width_out}), 96'({1'b0, 1'b0, 16'd640}));
      end
      vip_ctrl_busy = 1'b1;

      // Reset asserted mid-stream
      vip_ctrl_valid = 1'b1;
      width_in = 16'd4;
      height_in = 16'd2;
      interlaced_in = 4'd7;
      tick();
      vip_ctrl_valid = 1'b0;
      wait_send("send_pre_reset");
      beat(1'b0);
      beat(1'b0);
      beat(1'b0);
      chk("pre_reset", 96'({x_pos, proc_enable, width_out}), 96'({16'd3, 1'b1, 16'd4}));
      rst = 1'b0;
      beat_in = 1'b1;
      tick();
      beat_in = 1'b0;
      rst = 1'b1;
      chk_reset_state("reset_mid_stream");
      tick();
      chk("reset_stays_idle", 96'({proc_enable, vip_ctrl_send}), 96'({1'b0, 1'b0}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vip_frame_sequencer.md
Name: vip_frame_sequencer

Overview:
Frame-level controller for the VIP pixel-processing core. Latches frame dimensions from decoded control packets and schedules the outgoing control packet against encoder busy. Gates the core's pixel read enable per frame and tracks the pixel raster position. Checks received end_of_video against the expected frame size, and drops or flags malformed frames so the output stream stays frame-aligned.

Parameters:
DEF_WIDTH, 640, frame width used after reset until the first valid control packet
DEF_HEIGHT, 480, frame height used after reset until the first valid control packet
CNT_W, 16, width of the dimension registers and raster counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge)
vip_ctrl_valid  in  1  decoder control packet valid, one-cycle pulse
width_in  in  CNT_W  decoded frame width
height_in  in  CNT_W  decoded frame height
interlaced_in  in  4  decoded interlace field
vip_ctrl_busy  in  1  encoder busy; a control packet is not issued while high
vip_ctrl_send  out  1  one-cycle request to the encoder to emit a control packet
width_out  out  CNT_W  frame width of the frame being streamed
height_out  out  CNT_W  frame height of the frame being streamed
interlaced_out  out  4  interlace field of the frame being streamed
beat_in  in  1  core accepted a pixel this cycle (core read & ~stall_in)
eop_in  in  1  end_of_video qualifying beat_in
proc_enable  out  1  permits the core to read pixels
drop  out  1  core must discard accepted beats (no write)
x_pos  out  CNT_W  column of the next beat
y_pos  out  CNT_W  row of the next beat
sof  out  1  next beat is pixel (0,0)
eol_pulse  out  1  registered pulse: the last column of a row was accepted
frame_done  out  1  registered pulse: the frame ended correctly
err_short  out  1  sticky: eop arrived before the expected pixel count
err_long  out  1  sticky: expected pixel count was reached without eop
frame_count  out  CNT_W  number of correctly completed frames, wraps at 2^CNT_W

Behaviour:
- Reset values:
  - State IDLE; proc_enable=0, drop=0, vip_ctrl_send=0.
  - width_out=DEF_WIDTH, height_out=DEF_HEIGHT, interlaced_out=0.
  - x_pos=0, y_pos=0, all pulses and sticky errors 0, frame_count=0.
  - Reset mid-frame aborts the frame immediately; no error is flagged.
- Shadow registers (shd_w, shd_h, shd_i, pend):
  - Loaded on vip_ctrl_valid in any state, provided width_in!=0 and height_in!=0.
  - A zero-dimension packet is ignored entirely.
  - A later packet overwrites an unconsumed one (last wins).
- IDLE: proc_enable=0. Leaves for ARM when pend==1.
- ARM:
  - Copy the shadow registers to the *_out registers and clear pend in the same cycle; if vip_ctrl_valid coincides, pend stays 1 with the new values.
  - Reset x_pos and y_pos to 0. Next cycle go to SEND.
- SEND:
  - proc_enable=0.
  - If vip_ctrl_busy==0, vip_ctrl_send=1 for exactly one cycle, then go to STREAM.
  - Otherwise wait in SEND with vip_ctrl_send=0.
- STREAM: proc_enable=1, drop=0. On each beat_in:
  - If x_pos==width_out-1: x_pos wraps to 0, y_pos increments, eol_pulse=1 on the next cycle.
  - Otherwise x_pos increments.
  - Last pixel (x_pos==w-1, y_pos==h-1) with eop_in: frame_done, frame_count++, go to ARM if pend==1, else SEND (the current dimensions are re-sent).
  - eop_in before the last pixel: err_short is set, then the same transition as a good frame, without frame_done or a count increment.
  - Last pixel without eop_in: err_long is set, go to FLUSH.
- FLUSH:
  - proc_enable=1, drop=1; accepted beats are discarded and raster counters hold.
  - On beat_in & eop_in, go to ARM or SEND as in STREAM.
- Control while streaming: a vip_ctrl_valid during STREAM or FLUSH never changes the *_out registers mid-frame.
- Timing:
  - sof is combinational: (state==STREAM) & x_pos==0 & y_pos==0.
  - Counter update latency is one cycle from beat_in.
- Sticky errors: err_short and err_long clear only on reset.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, ARM, SEND, STREAM, FLUSH.
  - DEF_WIDTH and DEF_HEIGHT defaults.
  - CNT_W.
- One natural sub-module, vip_raster_counter: x/y wrap counter with inputs beat, clear, width and height, and outputs x, y, last_col and last_pix.

Test Plan:
- Reset, then ctrl 4x2, busy=0 -> vip_ctrl_send pulses once, then 8 beats with eop on the 8th -> frame_done=1, frame_count=1, eol_pulse twice, FSM returns to SEND.
- Ctrl 4x2 with busy held high for 5 cycles -> vip_ctrl_send stays 0 during busy, pulses the cycle after busy falls, proc_enable stays 0 until then.
- Ctrl 4x2, eop on beat 5 -> err_short=1, frame_count unchanged, next frame x_pos=y_pos=0.
- Ctrl 4x2, 8 beats without eop, then 3 more beats with eop on the 3rd -> err_long=1, drop=1 for the 3 beats, no frame_done.
- Mid-frame ctrl 2x2 during a 4x2 frame -> width_out stays 4 until the frame ends, then the next SEND carries 2x2 and the next frame completes after 4 beats.
- Ctrl with width_in=0 -> ignored, state stays IDLE; reset asserted mid-STREAM -> all outputs at reset values on the next cycle.
